// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - producer and uart byte-write bundle for uart_tx_arbiter
//
// Purpose: groups the byte producers' request lines and the uart wrapper's
// byte-write port into one bundle.
//   req_data   8*NUM_REQ  byte from requester i at [8i+7:8i]
//   req_valid  NUM_REQ    requester i has a byte
//   req_ready  NUM_REQ    one-hot accept strobe back to the requesters
//   uart_data  8          byte presented to the uart wrapper
//   uart_valid 1          byte pending at the uart wrapper
//   uart_ack   1          one-cycle accept pulse from the uart wrapper
// Modports: master = environment (producers + uart wrapper), slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           uart_data;
  logic                 uart_valid;
  logic                 uart_ack;

  modport master (
    output req_data, req_valid, uart_ack,
    input  req_ready, uart_data, uart_valid
  );

  modport slave (
    input  req_data, req_valid, uart_ack,
    output req_ready, uart_data, uart_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart byte-write port
//
// Purpose: grants the single uart byte port to one of NUM_REQ producers per
// byte, round-robin, with one byte in flight. IDLE -> SEND -> GAP -> IDLE.
// Optional line lock (macro UART_ARB_LOCK_EN): a producer keeps the port
// until it sends 8'h0A or stays quiet for LOCK_TIMEOUT idle cycles.
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   bus       uart_tx_arbiter_if.slave (req_data/req_valid/req_ready,
//             uart_data/uart_valid/uart_ack)
//   grant_id  index of the requester owning the current/last byte
//   busy      high whenever the FSM is not in IDLE
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus,
  output logic [2:0]        grant_id,
  output logic              busy
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and LOCK_TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e     state_q, state_d;
  logic [7:0] uart_data_q, uart_data_d;
  logic       uart_valid_q, uart_valid_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] eligible;
  logic [7:0]         elig8;
  logic               pick_found;
  logic [2:0]         pick_idx;
  logic [7:0]         pick_byte;
  logic               accept;
  logic [2:0]         next_ptr;
  logic               rr_hold;

  assign elig8 = 8'(eligible);

  // Scan rr_ptr, rr_ptr+1, ... downward so the candidate closest to the
  // pointer is the last one written and therefore wins.
  always_comb begin
    logic [3:0] sum;
    sum        = 4'd0;
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + 4'(k);
      if (sum >= 4'(NUM_REQ)) begin
        sum = sum - 4'(NUM_REQ);
      end
      if (elig8[sum[2:0]]) begin
        pick_found = 1'b1;
        pick_idx   = sum[2:0];
      end
    end
  end

  assign pick_byte     = bus.req_data[{pick_idx, 3'b000} +: 8];
  assign accept        = (state_q == IDLE) && pick_found;
  assign next_ptr      = (pick_idx == 3'(NUM_REQ - 1)) ? 3'd0 : pick_idx + 3'd1;
  assign bus.req_ready = accept ? (NUM_REQ'(1) << pick_idx) : '0;

`ifdef UART_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic             lock_q, lock_d;
  logic [2:0]       lock_id_q, lock_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       valid8;

  assign valid8   = 8'(bus.req_valid);
  assign eligible = lock_q ? (bus.req_valid & (NUM_REQ'(1) << lock_id_q)) : bus.req_valid;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    cnt_d     = cnt_q;
    rr_hold   = 1'b0;
    if (accept) begin
      cnt_d = '0;
      if (pick_byte == 8'h0A) begin
        lock_d = 1'b0;
      end else begin
        // Pointer stays put while a line is open so release resumes fairly.
        lock_d    = 1'b1;
        lock_id_d = pick_idx;
        rr_hold   = 1'b1;
      end
    end else if (lock_q && state_q == IDLE && !valid8[lock_id_q]) begin
      // The cycle that completes LOCK_TIMEOUT quiet cycles drops the lock.
      if (cnt_q >= CNT_W'(LOCK_TIMEOUT - 1)) begin
        lock_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= 3'd0;
      cnt_q     <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      cnt_q     <= cnt_d;
    end
  end
`else
  assign eligible = bus.req_valid;
  assign rr_hold  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    uart_data_d  = uart_data_q;
    uart_valid_d = uart_valid_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          uart_data_d  = pick_byte;
          grant_d      = pick_idx;
          uart_valid_d = 1'b1;
          state_d      = SEND;
          if (!rr_hold) begin
            rr_ptr_d = next_ptr;
          end
        end
      end
      SEND: begin
        if (bus.uart_ack) begin
          uart_valid_d = 1'b0;
          state_d      = GAP;
        end
      end
      GAP: begin
        // Wrapper needs valid low for a cycle between bytes.
        state_d = IDLE;
      end
      default: begin
        uart_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      uart_data_q  <= 8'd0;
      uart_valid_q <= 1'b0;
      grant_q      <= 3'd0;
      rr_ptr_q     <= 3'd0;
    end else begin
      state_q      <= state_d;
      uart_data_q  <= uart_data_d;
      uart_valid_q <= uart_valid_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign bus.uart_data  = uart_data_q;
  assign bus.uart_valid = uart_valid_q;
  assign grant_id       = grant_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard testbench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NR = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] grant_id;
  logic       busy;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

  uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  pmem [NR][16];
  int          prd [NR];
  int          pwr [NR];
  logic [10:0] exp_q [$];
  logic [NR-1:0] rdy_l;
  int          rdy_cnt [NR];
  int          vrun, last_vrun;
  bit          gap_chk, idle_chk;
  bit          auto_ack, extra_ack, force_ack, prev_ack, ack_now;
  int          ack_lat, vcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic send(input int r, input logic [7:0] b);
    pmem[r][pwr[r] % 16] = b;
    pwr[r]++;
  endtask

  task automatic expect_byte(input logic [2:0] g, input logic [7:0] b);
    exp_q.push_back({g, b});
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (prd[i] != pwr[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int total_ready();
    int s = 0;
    for (int i = 0; i < NR; i++) s += rdy_cnt[i];
    return s;
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
    last_vrun = 0;
    vrun = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pending() || busy || bus.uart_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    check(name, {31'd0, (n < 500) && (exp_q.size() == 0)}, 32'd1);
  endtask

  // Producer and uart-wrapper model: updates inputs just after each edge.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.uart_ack  = 1'b0;
    vcnt = 0;
    prev_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (rdy_l[i]) prd[i]++;
      for (int i = 0; i < NR; i++) begin
        bus.req_valid[i] = (prd[i] != pwr[i]);
        bus.req_data[8*i +: 8] = pmem[i][prd[i] % 16];
      end
      vcnt = bus.uart_valid ? vcnt + 1 : 0;
      ack_now = auto_ack && bus.uart_valid && (vcnt == ack_lat);
      bus.uart_ack = ack_now || (extra_ack && prev_ack) || force_ack;
      prev_ack = ack_now;
      force_ack = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every uart handshake.
  initial begin
    logic [10:0] e;
    rdy_l = '0;
    forever begin
      @(negedge clk);
      rdy_l = bus.req_ready;
      if (!rst_n) begin
        gap_chk = 1'b0;
        idle_chk = 1'b0;
        vrun = 0;
      end else begin
        if (idle_chk) begin
          check("idle_after_gap", {31'd0, busy}, 32'd0);
          idle_chk = 1'b0;
        end
        if (gap_chk) begin
          check("gap_busy", {31'd0, busy}, 32'd1);
          check("gap_valid_low", {31'd0, bus.uart_valid}, 32'd0);
          gap_chk = 1'b0;
          idle_chk = 1'b1;
        end
        for (int i = 0; i < NR; i++) if (rdy_l[i]) rdy_cnt[i]++;
        if (rdy_l != '0) check("ready_onehot", {31'd0, $onehot(rdy_l)}, 32'd1);
        if (bus.uart_valid) vrun++;
        if (bus.uart_valid && bus.uart_ack) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h from %0d expected none", bus.uart_data, grant_id);
          end else begin
            e = exp_q.pop_front();
            check("byte_data", {24'd0, bus.uart_data}, {24'd0, e[7:0]});
            check("byte_grant", {29'd0, grant_id}, {29'd0, e[10:8]});
          end
          last_vrun = vrun;
          vrun = 0;
          gap_chk = 1'b1;
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < NR; i++) begin
      prd[i] = 0;
      pwr[i] = 0;
    end
    auto_ack = 1'b1;
    extra_ack = 1'b0;
    force_ack = 1'b0;
    ack_lat = 3;
    clear_counts();

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, bus.uart_valid}, 32'd0);
    check("rst_data", {24'd0, bus.uart_data}, 32'd0);
    check("rst_grant", {29'd0, grant_id}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {28'd0, bus.req_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte, ack 3 cycles after valid
    clear_counts();
    send(0, 8'h41);
    expect_byte(3'd0, 8'h41);
    wait_idle("t1_drain");
    check("t1_valid_cycles", last_vrun, 32'd3);
    check("t1_ready0", rdy_cnt[0], 32'd1);
    check("t1_ready_total", total_ready(), 32'd1);

    // All four requesters busy: strict round-robin from req0
    do_reset();
    clear_counts();
    ack_lat = 1;
    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r < NR; r++) begin
        send(r, 8'(16 * r + b));
        expect_byte(3'(r), 8'(16 * r + b));
      end
    end
    wait_idle("t2_drain");
    for (int r = 0; r < NR; r++) check("t2_ready_count", rdy_cnt[r], 32'd4);

    // Ack while IDLE, then ack during GAP
    clear_counts();
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_idle_ack_busy", {31'd0, busy}, 32'd0);
    check("t3_idle_ack_valid", {31'd0, bus.uart_valid}, 32'd0);
    check("t3_idle_ack_ready", total_ready(), 32'd0);
    extra_ack = 1'b1;
    send(2, 8'h5A);
    send(2, 8'hA5);
    expect_byte(3'd2, 8'h5A);
    expect_byte(3'd2, 8'hA5);
    wait_idle("t3_drain");
    check("t3_ready2", rdy_cnt[2], 32'd2);
    check("t3_ready_total", total_ready(), 32'd2);
    extra_ack = 1'b0;

    // Reset during SEND; late ack ignored; next accept starts at req0
    do_reset();
    clear_counts();
    auto_ack = 1'b0;
    send(2, 8'h77);
    n = 0;
    while (!bus.uart_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_sending", {31'd0, bus.uart_valid}, 32'd1);
    check("t4_send_grant", {29'd0, grant_id}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t4_valid_after_rst", {31'd0, bus.uart_valid}, 32'd0);
    check("t4_busy_after_rst", {31'd0, busy}, 32'd0);
    check("t4_grant_after_rst", {29'd0, grant_id}, 32'd0);
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_late_ack_busy", {31'd0, busy}, 32'd0);
    check("t4_no_reissue", total_ready(), 32'd1);
    auto_ack = 1'b1;
    ack_lat = 2;
    send(3, 8'h33);
    send(0, 8'h30);
    expect_byte(3'd0, 8'h30);
    expect_byte(3'd3, 8'h33);
    wait_idle("t4_drain");

`ifdef UART_ARB_LOCK_EN
    // Line lock holds req1 until newline
    do_reset();
    clear_counts();
    ack_lat = 1;
    send(1, 8'h41);
    send(1, 8'h42);
    send(1, 8'h0A);
    send(2, 8'h55);
    expect_byte(3'd1, 8'h41);
    expect_byte(3'd1, 8'h42);
    expect_byte(3'd1, 8'h0A);
    expect_byte(3'd2, 8'h55);
    wait_idle("t5_drain");

    // Lock released after 8 quiet idle cycles
    do_reset();
    clear_counts();
    ack_lat = 2;
    send(1, 8'h41);
    send(2, 8'h66);
    expect_byte(3'd1, 8'h41);
    expect_byte(3'd2, 8'h66);
    n = 0;
    while (!(busy && !bus.uart_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("t6_quiet_cycles", n, 32'd8);
    check("t6_ready_req2", {28'd0, bus.req_ready}, 32'h4);
    wait_idle("t6_drain");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
